// File: rtl/main_ram_mp_pkg.sv
// Shared constants and width helpers for the dual-port, multi-bank main RAM.
package main_ram_mp_pkg;

  localparam int DEF_ADDR_WIDTH = 15;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BANK_BITS  = 1;

  localparam logic PORT_HOST = 1'b0;
  localparam logic PORT_VID  = 1'b1;

  function automatic int bank_count(input int bank_bits);
    return 32'sd1 << bank_bits;
  endfunction

  // The upper BANK_BITS of a port address pick the bank; the rest index into it.
  function automatic int bank_addr_width(input int addr_width, input int bank_bits);
    return addr_width - bank_bits;
  endfunction

endpackage

// File: rtl/main_ram_bank.sv
// One single-port bank: byte-masked write, registered read.
// MAIN_RAM_ICE40UP selects SB_SPRAM256KA primitives (16 bits each) instead of a behavioural array.
module main_ram_bank
  import main_ram_mp_pkg::*;
#(
  parameter int AW = DEF_ADDR_WIDTH - DEF_BANK_BITS,
  parameter int DW = DEF_DATA_WIDTH
) (
  input  logic            clk,
  input  logic            i_en,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [DW-1:0]   i_wdata,
  input  logic [DW/8-1:0] i_bytesel,
  output logic [DW-1:0]   o_rdata
);

`ifdef MAIN_RAM_ICE40UP
  logic [DW-1:0] w_rdata;

  for (genvar s = 0; s < DW/16; s++) begin : g_spram
    // MASKWREN works on nibbles, so each byte enable drives two mask bits.
    SB_SPRAM256KA u_spram (
      .ADDRESS    (i_addr),
      .DATAIN     (i_wdata[s*16 +: 16]),
      .MASKWREN   ({i_bytesel[2*s+1], i_bytesel[2*s+1], i_bytesel[2*s], i_bytesel[2*s]}),
      .WREN       (i_we),
      .CHIPSELECT (i_en),
      .CLOCK      (clk),
      .STANDBY    (1'b0),
      .SLEEP      (1'b0),
      .POWEROFF   (1'b1),
      .DATAOUT    (w_rdata[s*16 +: 16])
    );
  end

  assign o_rdata = w_rdata;
`else
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Byte-masked write port.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < DW/8; i++) begin
        if (i_bytesel[i]) begin
          r_mem[i_addr][i*8 +: 8] <= i_wdata[i*8 +: 8];
        end
      end
    end
  end

  // Read register holds its word until the next read of this bank.
  always_ff @(posedge clk) begin
    if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/main_ram_mp.sv
// Dual-port multi-bank main RAM with per-bank round-robin arbitration.
// MAIN_RAM_STATS_EN adds a saturating 16-bit same-bank conflict counter.
module main_ram_mp
  import main_ram_mp_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BANK_BITS  = DEF_BANK_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wrdata,
  input  logic [DATA_WIDTH/8-1:0] p0_wrbytesel,
  input  logic                    p0_write,
  input  logic                    p0_strobe,
  output logic                    p0_ack,
  output logic [DATA_WIDTH-1:0]   p0_rddata,
  output logic                    p0_rdvalid,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wrdata,
  input  logic [DATA_WIDTH/8-1:0] p1_wrbytesel,
  input  logic                    p1_write,
  input  logic                    p1_strobe,
  output logic                    p1_ack,
  output logic [DATA_WIDTH-1:0]   p1_rddata,
  output logic                    p1_rdvalid
`ifdef MAIN_RAM_STATS_EN
  ,
  output logic [15:0]             conflict_count
`endif
);

  localparam int NB = bank_count(BANK_BITS);
  localparam int IW = bank_addr_width(ADDR_WIDTH, BANK_BITS);
  localparam int BW = DATA_WIDTH / 8;

  logic [BANK_BITS-1:0]  w_p0_bank;
  logic [BANK_BITS-1:0]  w_p1_bank;
  logic                  w_conflict;
  logic                  w_p0_ack;
  logic                  w_p1_ack;
  logic [NB-1:0]         w_sel_p0;
  logic [NB-1:0]         w_sel_p1;
  logic [DATA_WIDTH-1:0] w_bank_rdata [NB];

  logic [NB-1:0]         r_last_grant;
  logic                  r_p0_rdvalid;
  logic                  r_p1_rdvalid;
  logic [BANK_BITS-1:0]  r_p0_bank;
  logic [BANK_BITS-1:0]  r_p1_bank;

  assign w_p0_bank  = p0_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_p1_bank  = p1_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign w_conflict = p0_strobe && p1_strobe && (w_p0_bank == w_p1_bank);

  // Grant: on a same-bank collision the port that did not win last time goes first.
  always_comb begin
    w_p0_ack = 1'b0;
    w_p1_ack = 1'b0;
    if (rst) begin
      w_p0_ack = 1'b0;
      w_p1_ack = 1'b0;
    end else if (w_conflict) begin
      if (r_last_grant[w_p0_bank] == PORT_VID) begin
        w_p0_ack = 1'b1;
      end else begin
        w_p1_ack = 1'b1;
      end
    end else begin
      w_p0_ack = p0_strobe;
      w_p1_ack = p1_strobe;
    end
  end

  assign p0_ack = w_p0_ack;
  assign p1_ack = w_p1_ack;

  for (genvar b = 0; b < NB; b++) begin : g_bank
    logic                  w_en;
    logic                  w_we;
    logic [IW-1:0]         w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [BW-1:0]         w_bytesel;

    assign w_sel_p0[b] = w_p0_ack && (w_p0_bank == BANK_BITS'(b));
    assign w_sel_p1[b] = w_p1_ack && (w_p1_bank == BANK_BITS'(b));

    // At most one port is granted per bank, so a simple 2:1 mux suffices.
    assign w_en      = w_sel_p0[b] || w_sel_p1[b];
    assign w_we      = w_sel_p1[b] ? p1_write             : p0_write;
    assign w_addr    = w_sel_p1[b] ? p1_addr[IW-1:0]      : p0_addr[IW-1:0];
    assign w_wdata   = w_sel_p1[b] ? p1_wrdata            : p0_wrdata;
    assign w_bytesel = w_sel_p1[b] ? p1_wrbytesel         : p0_wrbytesel;

    main_ram_bank #(
      .AW (IW),
      .DW (DATA_WIDTH)
    ) u_bank (
      .clk       (clk),
      .i_en      (w_en),
      .i_we      (w_we),
      .i_addr    (w_addr),
      .i_wdata   (w_wdata),
      .i_bytesel (w_bytesel),
      .o_rdata   (w_bank_rdata[b])
    );
  end

  // Per-bank last-grant flags; reset favours port 0 on the first collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= {NB{PORT_VID}};
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (w_sel_p0[b]) begin
          r_last_grant[b] <= PORT_HOST;
        end else if (w_sel_p1[b]) begin
          r_last_grant[b] <= PORT_VID;
        end
      end
    end
  end

  // Read-return tracking: valid flag and the bank whose output to forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_rdvalid <= 1'b0;
      r_p1_rdvalid <= 1'b0;
      r_p0_bank    <= {BANK_BITS{1'b0}};
      r_p1_bank    <= {BANK_BITS{1'b0}};
    end else begin
      r_p0_rdvalid <= w_p0_ack && !p0_write;
      r_p1_rdvalid <= w_p1_ack && !p1_write;
      if (w_p0_ack) begin
        r_p0_bank <= w_p0_bank;
      end
      if (w_p1_ack) begin
        r_p1_bank <= w_p1_bank;
      end
    end
  end

  // A reset arriving while a read result is due squashes it immediately.
  assign p0_rdvalid = r_p0_rdvalid && !rst;
  assign p1_rdvalid = r_p1_rdvalid && !rst;
  assign p0_rddata  = w_bank_rdata[r_p0_bank];
  assign p1_rddata  = w_bank_rdata[r_p1_bank];

`ifdef MAIN_RAM_STATS_EN
  logic [15:0] r_conflict_count;

  // Saturating count of same-bank collision cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_count <= 16'h0000;
    end else if (w_conflict && (r_conflict_count != 16'hFFFF)) begin
      r_conflict_count <= r_conflict_count + 16'h0001;
    end
  end

  assign conflict_count = r_conflict_count;
`endif

endmodule

// File: tb/tb_main_ram_mp.sv
// Self-checking bench for main_ram_mp: directed vector table, then random traffic
// against a behavioural memory/arbitration model; stats checks when MAIN_RAM_STATS_EN is set.
module tb_main_ram_mp;

  typedef struct {
    logic        rst;
    logic        s0, w0;
    logic [14:0] a0;
    logic [31:0] d0;
    logic [3:0]  b0;
    logic        s1, w1;
    logic [14:0] a1;
    logic [31:0] d1;
    logic [3:0]  b1;
    logic        k0, k1;   // expected acks
    logic        v0, v1;   // expected rdvalid next cycle
    logic [31:0] e0, e1;   // expected read data
    logic        c0, c1;   // read data is checkable
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] p0_addr = 15'h0, p1_addr = 15'h0;
  logic [31:0] p0_wrdata = 32'h0, p1_wrdata = 32'h0;
  logic [3:0]  p0_wrbytesel = 4'h0, p1_wrbytesel = 4'h0;
  logic        p0_write = 1'b0, p1_write = 1'b0;
  logic        p0_strobe = 1'b0, p1_strobe = 1'b0;
  logic        p0_ack, p1_ack, p0_rdvalid, p1_rdvalid;
  logic [31:0] p0_rddata, p1_rddata;
`ifdef MAIN_RAM_STATS_EN
  logic [15:0] conflict_count;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state: memory contents with per-byte known mask,
  // and which port wins the next collision in each bank.
  logic [31:0] mem_m [int];
  logic [3:0]  mem_k [int];
  bit          winner [2];
  bit          prev_v0 = 1'b0, prev_v1 = 1'b0;
  vec_t        tbl [$];

  main_ram_mp dut (
    .clk          (clk),
    .rst          (rst),
    .p0_addr      (p0_addr),
    .p0_wrdata    (p0_wrdata),
    .p0_wrbytesel (p0_wrbytesel),
    .p0_write     (p0_write),
    .p0_strobe    (p0_strobe),
    .p0_ack       (p0_ack),
    .p0_rddata    (p0_rddata),
    .p0_rdvalid   (p0_rdvalid),
    .p1_addr      (p1_addr),
    .p1_wrdata    (p1_wrdata),
    .p1_wrbytesel (p1_wrbytesel),
    .p1_write     (p1_write),
    .p1_strobe    (p1_strobe),
    .p1_ack       (p1_ack),
    .p1_rddata    (p1_rddata),
    .p1_rdvalid   (p1_rdvalid)
`ifdef MAIN_RAM_STATS_EN
    ,
    .conflict_count (conflict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r,
                     input logic s0, input logic w0, input logic [14:0] a0, input logic [31:0] d0, input logic [3:0] b0,
                     input logic s1, input logic w1, input logic [14:0] a1, input logic [31:0] d1, input logic [3:0] b1,
                     input logic k0, input logic k1,
                     input logic v0, input logic [31:0] e0, input logic v1, input logic [31:0] e1);
    vec_t v;
    v.rst = r;
    v.s0 = s0; v.w0 = w0; v.a0 = a0; v.d0 = d0; v.b0 = b0;
    v.s1 = s1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.b1 = b1;
    v.k0 = k0; v.k1 = k1; v.v0 = v0; v.v1 = v1; v.e0 = e0; v.e1 = e1;
    v.c0 = v0; v.c1 = v1;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] mem_rd(input logic [14:0] a);
    return mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0;
  endfunction

  function automatic bit mem_known(input logic [14:0] a);
    return mem_k.exists(int'(a)) && (mem_k[int'(a)] == 4'hF);
  endfunction

  // Expected outcome of one cycle, derived from the arbitration and memory rules.
  function automatic vec_t predict(input vec_t vi);
    vec_t v = vi;
    bit   same;
    same = v.s0 && v.s1 && (v.a0[14] == v.a1[14]);
    v.k0 = !v.rst && v.s0 && (!same || winner[v.a0[14]] == 1'b0);
    v.k1 = !v.rst && v.s1 && (!same || winner[v.a1[14]] == 1'b1);
    v.v0 = v.k0 && !v.w0;
    v.v1 = v.k1 && !v.w1;
    v.e0 = mem_rd(v.a0);
    v.e1 = mem_rd(v.a1);
    v.c0 = v.v0 && mem_known(v.a0);
    v.c1 = v.v1 && mem_known(v.a1);
    return v;
  endfunction

  task automatic mem_wr(input logic [14:0] a, input logic [31:0] d, input logic [3:0] be);
    if (!mem_k.exists(int'(a))) begin
      mem_k[int'(a)] = 4'h0;
      mem_m[int'(a)] = 32'h0;
    end
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem_m[int'(a)][i*8 +: 8] = d[i*8 +: 8];
        mem_k[int'(a)][i] = 1'b1;
      end
    end
  endtask

  // Drive one cycle, compare against v, and advance the model.
  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    rst = v.rst;
    p0_strobe = v.s0; p0_write = v.w0; p0_addr = v.a0; p0_wrdata = v.d0; p0_wrbytesel = v.b0;
    p1_strobe = v.s1; p1_write = v.w1; p1_addr = v.a1; p1_wrdata = v.d1; p1_wrbytesel = v.b1;
    #1;
    chk({tag, " p0_ack"}, {31'h0, p0_ack}, {31'h0, v.k0});
    chk({tag, " p1_ack"}, {31'h0, p1_ack}, {31'h0, v.k1});
    if (v.rst && (prev_v0 || prev_v1)) begin
      chk({tag, " p0_rdvalid squash"}, {31'h0, p0_rdvalid}, 32'h0);
      chk({tag, " p1_rdvalid squash"}, {31'h0, p1_rdvalid}, 32'h0);
    end
    if (v.rst) begin
      winner[0] = 1'b0;
      winner[1] = 1'b0;
    end else begin
      if (v.k0) begin
        winner[v.a0[14]] = 1'b1;
        if (v.w0) mem_wr(v.a0, v.d0, v.b0);
      end
      if (v.k1) begin
        winner[v.a1[14]] = 1'b0;
        if (v.w1) mem_wr(v.a1, v.d1, v.b1);
      end
    end
    @(posedge clk);
    #1;
    chk({tag, " p0_rdvalid"}, {31'h0, p0_rdvalid}, {31'h0, v.v0});
    chk({tag, " p1_rdvalid"}, {31'h0, p1_rdvalid}, {31'h0, v.v1});
    if (v.v0 && v.c0) chk({tag, " p0_rddata"}, p0_rddata, v.e0);
    if (v.v1 && v.c1) chk({tag, " p1_rddata"}, p1_rddata, v.e1);
    prev_v0 = v.v0;
    prev_v1 = v.v1;
  endtask

  function automatic logic [14:0] rnd_addr();
    logic [14:0] a;
    a = {1'($urandom_range(0, 1)), 14'($urandom_range(0, 7))};
    return a;
  endfunction

  initial begin
    vec_t cur;
    vec_t v;
    winner[0] = 1'b0;
    winner[1] = 1'b0;

    // rst, s0 w0 a0 d0 b0, s1 w1 a1 d1 b1, ack0 ack1, rv0 rd0, rv1 rd1
    add(1'b1, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b1, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,15'h0001,32'hDEADBEEF,4'hF, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'hDEADBEEF,  1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,15'h0005,32'h55555555,4'hF, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,15'h0002,32'h11223344,4'hF, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,15'h0002,32'hAABBCCDD,4'h5, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0002,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'h11BB33DD,  1'b0,32'h0);
    add(1'b0, 1'b1,1'b1,15'h0003,32'h33333333,4'hF, 1'b1,1'b1,15'h4003,32'h44444444,4'hF, 1'b1,1'b1, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0003,32'h0,4'h0,        1'b1,1'b0,15'h4003,32'h0,4'h0,        1'b1,1'b1, 1'b1,32'h33333333,  1'b1,32'h44444444);
    add(1'b1, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b1,1'b0,15'h0002,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'hDEADBEEF,  1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b1,1'b0,15'h0002,32'h0,4'h0,        1'b0,1'b1, 1'b0,32'h0,         1'b1,32'h11BB33DD);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b1,1'b0,15'h0002,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'hDEADBEEF,  1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b1,1'b0,15'h0002,32'h0,4'h0,        1'b0,1'b1, 1'b0,32'h0,         1'b1,32'h11BB33DD);
    add(1'b0, 1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'hDEADBEEF,  1'b0,32'h0);
    add(1'b1, 1'b1,1'b1,15'h0005,32'hFFFFFFFF,4'hF, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b0,1'b0, 1'b0,32'h0,         1'b0,32'h0);
    add(1'b0, 1'b1,1'b0,15'h0005,32'h0,4'h0,        1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b1,1'b0, 1'b1,32'h55555555,  1'b0,32'h0);
    add(1'b0, 1'b0,1'b0,15'h0000,32'h0,4'h0,        1'b1,1'b0,15'h0001,32'h0,4'h0,        1'b0,1'b1, 1'b0,32'h0,         1'b1,32'hDEADBEEF);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Random traffic; a stalled request is held unchanged until acked.
    cur = tbl[0];
    cur.s0 = 1'b0;
    cur.s1 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if (!cur.s0 && $urandom_range(0, 9) < 7) begin
        cur.s0 = 1'b1; cur.w0 = 1'($urandom_range(0, 1)); cur.a0 = rnd_addr();
        cur.d0 = $urandom; cur.b0 = 4'($urandom_range(0, 15));
      end
      if (!cur.s1 && $urandom_range(0, 9) < 7) begin
        cur.s1 = 1'b1; cur.w1 = 1'($urandom_range(0, 1)); cur.a1 = rnd_addr();
        cur.d1 = $urandom; cur.b1 = 4'($urandom_range(0, 15));
      end
      cur.rst = ($urandom_range(0, 99) == 0);
      v = predict(cur);
      apply(v, $sformatf("rnd%0d", n));
      if (v.k0) cur.s0 = 1'b0;
      if (v.k1) cur.s1 = 1'b0;
    end

`ifdef MAIN_RAM_STATS_EN
    cur = tbl[0];
    cur.rst = 1'b1;
    apply(predict(cur), "stats rst");
    chk("conflict_count reset", {16'h0, conflict_count}, 32'h0);
    cur.rst = 1'b0;
    cur.s0 = 1'b1; cur.w0 = 1'b0; cur.a0 = 15'h0001;
    cur.s1 = 1'b1; cur.w1 = 1'b0; cur.a1 = 15'h0002;
    for (int i = 0; i < 3; i++) apply(predict(cur), "stats same");
    cur.a1 = 15'h4003;
    for (int i = 0; i < 2; i++) apply(predict(cur), "stats diff");
    chk("conflict_count 3", {16'h0, conflict_count}, 32'd3);
    @(negedge clk);
    p1_addr = 15'h0002;
    repeat (70000) @(posedge clk);
    #1;
    chk("conflict_count saturate", {16'h0, conflict_count}, 32'h0000FFFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("conflict_count clear", {16'h0, conflict_count}, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
